rgb_gray_seq: RTL and testbench

- Sequencing controller that computes Y = 0.299*R + 0.587*G + 0.114*B for IEEE-754 single-precision pixels.
- Uses ONE shared fp multiplier and ONE shared fp adder; both units are instantiated outside this block.
- Accepts a pixel on a valid/ready input channel, runs five operations in order (3 multiplies, 2 adds), then presents Y on a valid/ready output channel.
- Used by pixel pipelines where area matters more than throughput.

---
 rtl/rgb_gray_seq.sv | 190 +++++++++++++++++++
 tb/tb_rgb_gray_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_gray_seq.sv
// rgb_gray_seq: computes Y = C_R*R + C_G*G + C_B*B on fp32 pixels by
// sequencing one shared external multiplier and one shared external adder
// through three multiply phases and two add phases.
module rgb_gray_seq #(
   parameter int MUL_LAT = 1,
   parameter int ADD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_r,
   input  logic [31:0] in_g,
   input  logic [31:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_y,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [31:0] mul_out,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   input  logic [31:0] add_out,
   output logic        busy
);

   localparam logic [31:0] C_R = 32'h3E991687;
   localparam logic [31:0] C_G = 32'h3F1645A2;
   localparam logic [31:0] C_B = 32'h3DE978D5;

   localparam int MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] ADD_LAST = CNT_W'(ADD_LAT);

   typedef enum logic [2:0] {IDLE, MR, MG, MB, A1, A2, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      g_q, g_d;
   logic [31:0]      b_q, b_d;
   logic [31:0]      p0_q, p0_d;
   logic [31:0]      p1_q, p1_d;
   logic [31:0]      p2_q, p2_d;
   logic [31:0]      s_q, s_d;
   logic [31:0]      mul_a_q, mul_a_d;
   logic [31:0]      mul_b_q, mul_b_d;
   logic [31:0]      add_a_q, add_a_d;
   logic [31:0]      add_b_q, add_b_d;
   logic [31:0]      out_y_q, out_y_d;
   logic             out_valid_q, out_valid_d;

   logic             op_phase;
   logic             mul_phase;
   logic             phase_end;

   // Next-state, phase counting, operand loading and result capture
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      g_d         = g_q;
      b_d         = b_q;
      p0_d        = p0_q;
      p1_d        = p1_q;
      p2_d        = p2_q;
      s_d         = s_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      out_y_d     = out_y_q;
      out_valid_d = out_valid_q;

      mul_phase = (state_q == MR) || (state_q == MG) || (state_q == MB);
      op_phase  = mul_phase || (state_q == A1) || (state_q == A2);
      // The unit result is taken on the edge that ends cycle LAT of a phase.
      phase_end = op_phase && (cnt_q == (mul_phase ? MUL_LAST : ADD_LAST));

      if (op_phase) begin
         cnt_d = phase_end ? '0 : cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               g_d     = in_g;
               b_d     = in_b;
               mul_a_d = in_r;
               mul_b_d = C_R;
               cnt_d   = '0;
               state_d = MR;
            end
         end
         MR: begin
            if (phase_end) begin
               p0_d    = mul_out;
               mul_a_d = g_q;
               mul_b_d = C_G;
               state_d = MG;
            end
         end
         MG: begin
            if (phase_end) begin
               p1_d    = mul_out;
               mul_a_d = b_q;
               mul_b_d = C_B;
               state_d = MB;
            end
         end
         MB: begin
            if (phase_end) begin
               p2_d    = mul_out;
               add_a_d = p0_q;
               add_b_d = p1_q;
               state_d = A1;
            end
         end
         A1: begin
            if (phase_end) begin
               s_d     = add_out;
               add_a_d = add_out;
               add_b_d = p2_q;
               state_d = A2;
            end
         end
         A2: begin
            if (phase_end) begin
               out_y_d     = add_out;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            // Output handshake only; a waiting input is taken from IDLE later.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any pixel in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         g_q         <= '0;
         b_q         <= '0;
         p0_q        <= '0;
         p1_q        <= '0;
         p2_q        <= '0;
         s_q         <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         out_y_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         g_q         <= g_d;
         b_q         <= b_d;
         p0_q        <= p0_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
         s_q         <= s_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         out_y_q     <= out_y_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;

endmodule

// File: tb/tb_rgb_gray_seq.sv
// Directed bench for rgb_gray_seq with behavioural fp32 multiplier/adder
// models; a second instance runs with longer unit latencies.
module tb_rgb_gray_seq;

   localparam logic [31:0] F_ZERO = 32'h00000000;
   localparam logic [31:0] F_ONE  = 32'h3F800000;
   localparam logic [31:0] F_HALF = 32'h3F000000;
   localparam logic [31:0] F_TWO  = 32'h40000000;
   localparam logic [31:0] F_255  = 32'h437F0000;
   localparam logic [31:0] C_R    = 32'h3E991687;
   localparam logic [31:0] C_G    = 32'h3F1645A2;
   localparam logic [31:0] C_B    = 32'h3DE978D5;
   // 255 * C_R rounded to fp32, and 76.245 rounded to fp32
   localparam logic [31:0] P0_255 = 32'h42987D70;
   localparam logic [31:0] Y_255  = 32'h42987D71;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
   logic [31:0] in_r = '0, in_g = '0, in_b = '0, out_y;
   logic [31:0] mul_a, mul_b, mul_out, add_a, add_b, add_out;

   logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1, busy_b;
   logic [31:0] in_r_b = '0, in_g_b = '0, in_b_b = '0, out_y_b;
   logic [31:0] mul_a_b, mul_b_b, mul_out_b, add_a_b, add_b_b, add_out_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_q[$];
   logic [31:0] out_q[$];

   logic [31:0] px_r[4] = '{F_ONE, F_HALF, F_TWO, F_255};
   logic [31:0] px_g[4] = '{F_ONE, F_HALF, F_TWO, F_ZERO};
   logic [31:0] px_y[4] = '{F_ONE, F_HALF, F_TWO, Y_255};

   always #5 clk = ~clk;

   rgb_gray_seq dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_r(in_r), .in_g(in_g), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
      .add_a(add_a), .add_b(add_b), .add_out(add_out),
      .busy(busy)
   );

   rgb_gray_seq #(.MUL_LAT(3), .ADD_LAT(2)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_r(in_r_b), .in_g(in_g_b), .in_b(in_b_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_y(out_y_b),
      .mul_a(mul_a_b), .mul_b(mul_b_b), .mul_out(mul_out_b),
      .add_a(add_a_b), .add_b(add_b_b), .add_out(add_out_b),
      .busy(busy_b)
   );

   // fp32 <-> real for normal numbers; zero/denormal inputs read as 0.0
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      int e;
      if (f[30:23] == 8'd0) return 0.0;
      e = int'(f[30:23]) - 127 + 1023;
      d = {f[31], e[10:0], f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [31:0] body;
      int e;
      d = $realtobits(r);
      if (d[62:52] == 11'd0) return {d[63], 31'd0};
      e = int'(d[62:52]) - 1023 + 127;
      if (e <= 0) return {d[63], 31'd0};
      body = {1'b0, e[7:0], d[51:29]};
      body = body + {31'd0, d[28]};
      return {d[63], body[30:0]};
   endfunction

   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      return r2f(f2r(a) * f2r(b));
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      return r2f(f2r(a) + f2r(b));
   endfunction

   function automatic bit close1(input logic [31:0] a, input logic [31:0] b);
      longint d;
      if ($isunknown(a)) return 1'b0;
      if (a[31] != b[31]) return 1'b0;
      d = longint'(a[30:0]) - longint'(b[30:0]);
      return (d >= -1) && (d <= 1);
   endfunction

   // Unit models: latency-1 pair for dut, latency 3/2 pair for dut_b
   always @(posedge clk) begin
      mul_out <= fmul(mul_a, mul_b);
      add_out <= fadd(add_a, add_b);
   end

   logic [31:0] mpipe_b[3];
   logic [31:0] apipe_b[2];
   always @(posedge clk) begin
      mpipe_b[0] <= fmul(mul_a_b, mul_b_b);
      mpipe_b[1] <= mpipe_b[0];
      mpipe_b[2] <= mpipe_b[1];
      apipe_b[0] <= fadd(add_a_b, add_b_b);
      apipe_b[1] <= apipe_b[0];
   end
   assign mul_out_b = mpipe_b[2];
   assign add_out_b = apipe_b[1];

   // Handshake monitor for dut: accept edges and delivered results
   always @(posedge clk) begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && out_ready) out_q.push_back(out_y);
      cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_ulp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (close1(obs, exp) === 1'b1) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (+/-1 ulp)", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int n_acc;
      int n_out;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_y", out_y, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_mul_a", mul_a, 32'd0);
      chk("rst_mul_b", mul_b, 32'd0);
      chk("rst_add_a", add_a, 32'd0);
      chk("rst_add_b", add_b, 32'd0);
      rst_n = 1'b1;

      // Basic pixel 1.0/1.0/1.0, latency 10
      @(negedge clk);
      in_r = F_ONE; in_g = F_ONE; in_b = F_ONE; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("basic_busy", 32'(busy), 32'd1);
      chk("basic_in_ready", 32'(in_ready), 32'd0);
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("basic_latency", 32'(n), 32'd10);
      chk_ulp("basic_y", out_y, F_ONE);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("basic_hs_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      out_ready = 1'b0;

      // Single channel R=255, operand sequence
      in_r = F_255; in_g = F_ZERO; in_b = F_ZERO; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("mr_mul_a", mul_a, F_255);
      chk("mr_mul_b", mul_b, C_R);
      repeat (2) @(posedge clk); #1;
      chk("mg_mul_a", mul_a, F_ZERO);
      chk("mg_mul_b", mul_b, C_G);
      repeat (2) @(posedge clk); #1;
      chk("mb_mul_a", mul_a, F_ZERO);
      chk("mb_mul_b", mul_b, C_B);
      repeat (2) @(posedge clk); #1;
      chk("a1_add_a", add_a, P0_255);
      chk("a1_add_b", add_b, F_ZERO);
      repeat (2) @(posedge clk); #1;
      chk("a2_add_a", add_a, P0_255);
      chk("a2_add_b", add_b, F_ZERO);
      repeat (2) @(posedge clk); #1;
      chk("r255_valid_edge10", 32'(out_valid), 32'd1);
      chk_ulp("r255_y", out_y, Y_255);

      // Backpressure: out_ready low for 5 cycles while in_valid toggles
      n_acc = acc_q.size();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         in_r = F_TWO; in_g = F_TWO; in_b = F_TWO;
         @(posedge clk); #1;
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk_ulp("bp_out_y", out_y, Y_255);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      chk("bp_no_accept", 32'(acc_q.size()), 32'(n_acc));
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", 32'(out_valid), 32'd0);
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      out_ready = 1'b0;

      // Reset during MB aborts the pixel
      n_out = out_q.size();
      in_r = F_ONE; in_g = F_ONE; in_b = F_ONE; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_mul_a", mul_a, 32'd0);
      chk("arst_mul_b", mul_b, 32'd0);
      chk("arst_add_a", add_a, 32'd0);
      chk("arst_add_b", add_b, 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (12) @(negedge clk);
      chk("arst_no_output", 32'(out_q.size()), 32'(n_out));
      out_ready = 1'b0;
      in_r = F_HALF; in_g = F_HALF; in_b = F_HALF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("half_latency", 32'(n), 32'd10);
      chk_ulp("half_y", out_y, F_HALF);
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Latency sweep on MUL_LAT=3, ADD_LAT=2 instance
      chk("lat_in_ready", 32'(in_ready_b), 32'd1);
      in_r_b = F_ONE; in_g_b = F_ONE; in_b_b = F_ONE; in_valid_b = 1'b1;
      @(posedge clk); #1;
      in_valid_b = 1'b0;
      n = 0;
      while (!out_valid_b && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk("lat_latency", 32'(n), 32'd18);
      chk_ulp("lat_y", out_y_b, F_ONE);

      // Back-to-back: in_valid and out_ready held high for 4 pixels
      @(negedge clk);
      acc_q.delete();
      out_q.delete();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_r = px_r[k]; in_g = px_g[k]; in_b = px_g[k]; in_valid = 1'b1;
         n_acc = acc_q.size();
         for (int t = 0; t < 40 && acc_q.size() == n_acc; t++) @(negedge clk);
         chk("b2b_accept", 32'(acc_q.size()), 32'(n_acc + 1));
      end
      in_valid = 1'b0;
      for (int t = 0; t < 60 && out_q.size() < 4; t++) @(negedge clk);
      chk("b2b_count", 32'(out_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < out_q.size(); i++) begin
         chk_ulp("b2b_y", out_q[i], px_y[i]);
      end
      for (int i = 0; i + 1 < acc_q.size(); i++) begin
         chk("b2b_spacing", 32'(acc_q[i+1] - acc_q[i]), 32'd12);
      end
      out_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
